// File: rtl/sp_ram_copier_pkg.sv
// Shared types and constants for the single-port RAM word copier.
//   state_e : copier FSM state encoding
//   BE_ALL  : byte-enable mask for a full 32-bit word write
package sp_ram_copier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/sp_ram_copier.sv
// Word-by-word copier for a single-port 32-bit RAM. Each word costs one read
// cycle followed by one write cycle, which forwards the read data.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i, abort_i              copy request (IDLE only) / early termination
//   src_addr_i, dst_addr_i, len_i byte addresses and word count of the copy
//   busy_o, done_o, err_o         status; err_o flags a misaligned request
//   count_o                       words written in the current/last copy
//   mem_*                         single-port RAM master interface
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start_i
// RD      | read presented at current source address
// WR      | previous read data written to current destination address
// DONE    | one-cycle completion pulse, err_o valid
module sp_ram_copier
    import sp_ram_copier_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = ADDR_WIDTH - 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [LEN_WIDTH-1:0]  count_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    input  logic [31:0]           mem_rdata_i
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic                  err_q, err_d;
    logic                  misaligned;

    assign misaligned = (|src_addr_i[1:0]) | (|dst_addr_i[1:0]);
    assign count_o    = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        count_d     = count_q;
        err_d       = err_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                // abort_i is deliberately not looked at here: start wins
                if (start_i) begin
                    src_d   = src_addr_i;
                    dst_d   = dst_addr_i;
                    len_d   = len_i;
                    count_d = '0;
                    err_d   = misaligned;
                    state_d = ((len_i == '0) || misaligned) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                busy_o     = 1'b1;
                mem_en_o   = 1'b1;
                mem_addr_o = src_q;
                state_d    = abort_i ? ST_DONE : ST_WR;
            end
            ST_WR: begin
                busy_o      = 1'b1;
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_be_o    = BE_ALL;
                mem_addr_o  = dst_q;
                mem_wdata_o = mem_rdata_i;
                // Pointers wrap modulo the address space by construction
                src_d       = src_q + ADDR_WIDTH'(4);
                dst_d       = dst_q + ADDR_WIDTH'(4);
                count_d     = count_q + LEN_WIDTH'(1);
                state_d     = ((count_d == len_q) || abort_i) ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sp_ram_copier.sv
module tb_sp_ram_copier;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i, abort_i;
    logic [11:0] src_addr_i, dst_addr_i;
    logic [10:0] len_i;
    logic        busy_o, done_o, err_o;
    logic [10:0] count_o;
    logic        mem_en_o, mem_we_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sp_ram_copier #(.ADDR_WIDTH(12)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .count_o(count_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // RAM attached to the DUT: read data one cycle after the address
    logic [31:0] ram [0:1023];
    bit          ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            if (mem_en_o && !mem_we_o) mem_rdata_i <= ram[mem_addr_o[11:2]];
            if (mem_en_o && mem_we_o)
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    // Reference memory image: what the RAM must hold after each copy
    logic [31:0] refmem [0:1023];

    typedef struct {
        int          cyc;
        logic        busy, done, err;
        logic [10:0] count;
        logic        en, we;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] rd_log[$];
    logic [11:0] wr_log[$];
    int          done_seen;
    int          err_seen;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare process: one expected entry per cycle while a copy is tracked
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("c%0d busy", e.cyc), 32'(busy_o), 32'(e.busy));
            chk($sformatf("c%0d done", e.cyc), 32'(done_o), 32'(e.done));
            chk($sformatf("c%0d err", e.cyc), 32'(err_o), 32'(e.err));
            chk($sformatf("c%0d count", e.cyc), 32'(count_o), 32'(e.count));
            chk($sformatf("c%0d en", e.cyc), 32'(mem_en_o), 32'(e.en));
            chk($sformatf("c%0d we", e.cyc), 32'(mem_we_o), 32'(e.we));
            chk($sformatf("c%0d be", e.cyc), 32'(mem_be_o), 32'(e.be));
            chk($sformatf("c%0d addr", e.cyc), 32'(mem_addr_o), 32'(e.addr));
            chk($sformatf("c%0d wdata", e.cyc), mem_wdata_o, e.wdata);
            if (mem_en_o && !mem_we_o) rd_log.push_back(mem_addr_o);
            if (mem_en_o && mem_we_o) wr_log.push_back(mem_addr_o);
            if (done_o) begin
                done_seen = e.cyc;
                err_seen  = int'(err_o);
            end
        end
    end

    // Builds the cycle-by-cycle expectation from the copy rules and drives the
    // request. abort_cyc: cycle (after start) during which abort_i is high
    // (0 = none). max_cyc: stop after this cycle (0 = run to completion).
    task automatic run_copy(int src, int dst, int len, int abort_cyc,
                            bit hold_start, bit abort_start, int max_cyc);
        int   words, done_c, last;
        bit   mis;
        exp_t e;
        logic [31:0] data;
        @(negedge clk);
        rd_log.delete(); wr_log.delete();
        done_seen = -1; err_seen = -1;
        mis = ((src % 4) != 0) || ((dst % 4) != 0);
        if (len == 0 || mis) begin
            words = 0; done_c = 1;
        end else begin
            words = len; done_c = 2 * len + 1;
            if (abort_cyc >= 1 && abort_cyc <= 2 * len) begin
                words  = abort_cyc / 2;
                done_c = abort_cyc + 1;
            end
        end
        last = (max_cyc != 0) ? max_cyc : done_c + 1;
        data = '0;
        for (int c = 1; c <= last; c++) begin
            e = '{cyc: c, busy: 0, done: 0, err: 0, count: 11'(words), en: 0, we: 0,
                  be: 4'h0, addr: 12'h0, wdata: 32'h0};
            if (c < done_c) begin
                e.busy  = 1'b1;
                e.en    = 1'b1;
                e.count = 11'((c - 1) / 2);
                if (c % 2 == 1) begin
                    e.addr = 12'(src + 2 * (c - 1));
                    data   = refmem[(src + 2 * (c - 1)) / 4 % 1024];
                end else begin
                    e.we    = 1'b1;
                    e.be    = 4'hF;
                    e.addr  = 12'(dst + 4 * (c / 2 - 1));
                    e.wdata = data;
                    refmem[(dst + 4 * (c / 2 - 1)) / 4 % 1024] = data;
                end
            end else if (c == done_c) begin
                e.done = 1'b1;
                e.err  = mis;
            end
            exp_q.push_back(e);
        end
        src_addr_i = 12'(src); dst_addr_i = 12'(dst); len_i = 11'(len);
        start_i = 1'b1; abort_i = abort_start;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start_i = hold_start && (c <= done_c);
            abort_i = (c == abort_cyc);
        end
        start_i = 1'b0; abort_i = 1'b0;
    endtask

    task automatic chk_ram(string name);
        int bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== refmem[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    task automatic chk_outputs_zero(string name);
        chk({name, " outs"}, {busy_o, done_o, err_o, mem_en_o, mem_we_o, mem_be_o}, 32'h0);
        chk({name, " count"}, 32'(count_o), 32'h0);
        chk({name, " addr"}, 32'(mem_addr_o), 32'h0);
        chk({name, " wdata"}, mem_wdata_o, 32'h0);
    endtask

    initial begin
        logic [11:0] ra [4];
        logic [31:0] w0;
        for (int i = 0; i < 1024; i++) refmem[i] = init_word(i);
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        src_addr_i = '0; dst_addr_i = '0; len_i = '0;
        @(negedge clk);
        chk_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk_outputs_zero("idle");

        // Basic copy; start held high throughout and abort with start in IDLE
        run_copy(32'h100, 32'h200, 4, 0, 1'b1, 1'b1, 0);
        chk("basic done cycle", 32'(done_seen), 32'd9);
        chk("basic count", 32'(count_o), 32'd4);
        chk("basic reads", 32'(rd_log.size()), 32'd4);
        chk("basic writes", 32'(wr_log.size()), 32'd4);
        if (rd_log.size() == 4) chk("basic last read", 32'(rd_log[3]), 32'h10C);
        if (wr_log.size() == 4) chk("basic last write", 32'(wr_log[3]), 32'h20C);
        chk("basic data", ram[32'h20C / 4], init_word(32'h10C / 4));
        chk_ram("basic ram");

        // Zero length
        run_copy(32'h100, 32'h200, 0, 0, 1'b0, 1'b0, 0);
        chk("len0 done cycle", 32'(done_seen), 32'd1);
        chk("len0 err", 32'(err_seen), 32'd0);
        chk("len0 accesses", 32'(rd_log.size() + wr_log.size()), 32'd0);

        // Misaligned source, then misaligned destination
        run_copy(32'h102, 32'h200, 2, 0, 1'b0, 1'b0, 0);
        chk("missrc done cycle", 32'(done_seen), 32'd1);
        chk("missrc err", 32'(err_seen), 32'd1);
        chk("missrc accesses", 32'(rd_log.size() + wr_log.size()), 32'd0);
        run_copy(32'h300, 32'h201, 3, 0, 1'b0, 1'b0, 0);
        chk("misdst err", 32'(err_seen), 32'd1);

        // Source wraps past the top of memory
        run_copy(32'hFF8, 32'h400, 4, 0, 1'b0, 1'b0, 0);
        ra[0] = 12'hFF8; ra[1] = 12'hFFC; ra[2] = 12'h000; ra[3] = 12'h004;
        chk("wrap reads", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("wrap read%0d", i), 32'(rd_log[i]), 32'(ra[i]));
        chk_ram("wrap ram");

        // Abort during third WR: that write completes
        run_copy(32'h600, 32'h700, 8, 6, 1'b0, 1'b0, 0);
        chk("abwr done cycle", 32'(done_seen), 32'd7);
        chk("abwr count", 32'(count_o), 32'd3);
        chk("abwr writes", 32'(wr_log.size()), 32'd3);
        chk("abwr untouched", ram[32'h70C / 4], init_word(32'h70C / 4));
        chk_ram("abwr ram");

        // Abort during third RD: no write for that word
        run_copy(32'h600, 32'h780, 5, 5, 1'b0, 1'b0, 0);
        chk("abrd done cycle", 32'(done_seen), 32'd6);
        chk("abrd writes", 32'(wr_log.size()), 32'd2);
        chk_ram("abrd ram");

        // Forward overlap smears the first source word
        w0 = refmem[32'h800 / 4];
        run_copy(32'h800, 32'h804, 4, 0, 1'b0, 1'b0, 0);
        chk("overlap smear", ram[32'h810 / 4], w0);
        chk_ram("overlap ram");

        // Reset during second RD (cycle 3)
        run_copy(32'h900, 32'hA00, 8, 0, 1'b0, 1'b0, 3);
        rst_ni = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("postreset en%0d", i), 32'(mem_en_o), 32'd0);
        end
        chk("midreset word0", ram[32'hA00 / 4], init_word(32'h900 / 4));
        chk("midreset word1", ram[32'hA04 / 4], init_word(32'hA04 / 4));
        chk_ram("midreset ram");

        // Copier still works after the reset
        run_copy(32'hB00, 32'hC00, 2, 0, 1'b0, 1'b0, 0);
        chk("after done cycle", 32'(done_seen), 32'd5);
        chk_ram("after ram");

        if (exp_q.size() != 0) chk("queue drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp_ram_copier.md
SP_RAM_COPIER -- requirements
Module: sp_ram_copier

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, byte-address width of the attached single-port RAM.
REQ-002 Parameter LEN_WIDTH, default ADDR_WIDTH-1, width of the word-count fields.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  copy request, sampled in IDLE only.
REQ-006 abort_i  input  1  terminate copy early.
REQ-007 src_addr_i  input  ADDR_WIDTH  source byte address.
REQ-008 dst_addr_i  input  ADDR_WIDTH  destination byte address.
REQ-009 len_i  input  LEN_WIDTH  number of 32-bit words to copy.
REQ-010 busy_o  output  1  copy in progress.
REQ-011 done_o  output  1  one-cycle completion pulse.
REQ-012 err_o  output  1  misalignment flag, valid with done_o.
REQ-013 count_o  output  LEN_WIDTH  words written in current/last copy.
REQ-014 mem_en_o  output  1  RAM enable.
REQ-015 mem_addr_o  output  ADDR_WIDTH  RAM byte address, bits[1:0] always 0.
REQ-016 mem_wdata_o  output  32  RAM write data.
REQ-017 mem_we_o  output  1  RAM write enable.
REQ-018 mem_be_o  output  4  RAM byte enables.
REQ-019 mem_rdata_i  input  32  RAM read data, valid the cycle after the read address is presented.

Function
REQ-020 FSM states IDLE, RD, WR, DONE; one word per RD+WR pair (2 cycles/word).
REQ-021 IDLE: start_i=1 latches src, dst, len, clears count_o; next state RD, or DONE if len_i=0 or src/dst bits[1:0]!=0.
REQ-022 Misaligned start: err_o=1 during the DONE cycle, no RAM access issued.
REQ-023 RD: mem_en_o=1, mem_we_o=0, mem_be_o=0, mem_addr_o=current src; next state WR.
REQ-024 WR: mem_en_o=1, mem_we_o=1, mem_be_o=4'hF, mem_addr_o=current dst, mem_wdata_o=mem_rdata_i; src and dst advance by 4, count_o increments.
REQ-025 WR exits to DONE when count_o+1=len or abort_i=1, else RD.
REQ-026 abort_i in RD: next state DONE, no write for that word; abort_i in WR: that write completes, then DONE.
REQ-027 DONE: done_o=1 for exactly one cycle, busy_o=0; next state IDLE.
REQ-028 busy_o=1 in RD and WR only; mem_en_o/mem_we_o/mem_be_o/mem_wdata_o zero outside RD/WR.
REQ-029 Address arithmetic modulo 2^ADDR_WIDTH; wrap past top of memory is silent and legal.
REQ-030 Overlapping regions copied strictly ascending; forward overlap smears source as a consequence (defined behaviour, not error).
REQ-031 start_i outside IDLE ignored; start_i and abort_i together in IDLE: start wins, abort ignored.
REQ-032 Latency: start at cycle 0, len=N valid -> last write cycle 2N, done_o at cycle 2N+1.

Reset
REQ-033 rst_ni low forces IDLE immediately; all outputs 0, count_o=0, latched fields 0.
REQ-034 Reset mid-copy: no further RAM access after deassertion; partially copied words remain.

Structure
REQ-035 Package sp_ram_copier_pkg holds state enum and constant BE_ALL=4'hF.
REQ-036 Single flat module; no sub-module required.

Verification
REQ-037 src=0x100, dst=0x200, len=4 -> reads 0x100..0x10C, writes 0x200..0x20C, done_o at cycle 9, count_o=4, data matches.
REQ-038 len=0 -> done_o at cycle 1, err_o=0, mem_en_o never asserted.
REQ-039 src=0x102, len=2 -> done_o and err_o at cycle 1, no RAM access.
REQ-040 ADDR_WIDTH=12, src=0xFF8, dst=0x400, len=4 -> reads 0xFF8, 0xFFC, 0x000, 0x004.
REQ-041 len=8, abort_i during third WR -> three words written, done_o next cycle, count_o=3.
REQ-042 rst_ni low during second RD -> outputs 0 immediately, first word written, no later writes.
